pwm_us_gen: RTL

- Microsecond-resolution PWM / pulse generator; output counterpart of the microsecond pulse-width measuring timer.
- Drives ESC/servo outputs of the FCU from a programmed period and high time in microseconds at CLK = 50 MHz.
- Double-buffered: new settings take effect only at a period boundary, so no glitched or runt pulses are produced.

---
 rtl/pwm_us_gen.sv | 68 ++++++
 1 files changed

// File: rtl/pwm_us_gen.sv
// pwm_us_gen: double-buffered microsecond PWM generator with period-boundary updates
module pwm_us_gen #(
    parameter logic [5:0] T1USval = 6'd49
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        En,
    input  logic [15:0] Period,
    input  logic [15:0] Duty,
    input  logic        Load,
    output logic        PWM_OUT,
    output logic        Cycle_done,
    output logic        Pending
);
    logic [5:0]  r_count;
    logic [15:0] r_cntus;
    logic [15:0] r_per_stg;
    logic [15:0] r_duty_stg;
    logic [15:0] r_per_sh;
    logic [15:0] r_duty_sh;
    logic        r_pending;
    logic        r_pwm;
    logic        r_cycle_done;
    logic        w_idle;
    logic        w_tick;
    logic        w_wrap;
    logic        w_apply;
    assign w_idle  = !En || (r_per_sh == 16'd0);
    assign w_tick  = (r_count == T1USval);
    assign w_wrap  = !w_idle && w_tick && (r_cntus == r_per_sh - 16'd1);
    // staged values reach the shadow only at a wrap or while idle
    assign w_apply = r_pending && (w_idle || w_wrap);
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_count      <= 6'd0;
            r_cntus      <= 16'd0;
            r_cycle_done <= 1'b0;
            r_pwm        <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_count      <= (w_idle || w_tick) ? 6'd0 : r_count + 6'd1;
            r_cntus      <= (w_idle || w_wrap) ? 16'd0 : (w_tick ? r_cntus + 16'd1 : r_cntus);
            r_cycle_done <= w_wrap;
            r_pwm        <= !w_idle && (r_cntus < r_duty_sh);
            r_pending    <= Load || (r_pending && !w_apply);
        end
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_per_stg  <= 16'd0;
            r_duty_stg <= 16'd0;
            r_per_sh   <= 16'd0;
            r_duty_sh  <= 16'd0;
        end else begin
            if (Load) begin
                r_per_stg  <= Period;
                r_duty_stg <= Duty;
            end
            if (w_apply) begin
                r_per_sh  <= r_per_stg;
                r_duty_sh <= r_duty_stg;
            end
        end
    end
    assign PWM_OUT    = r_pwm;
    assign Cycle_done = r_cycle_done;
    assign Pending    = r_pending;
endmodule
